// File: rtl/dtc_pkg.sv
// Shared types and defaults for the decision-tree share controller.
// No logic: constants, FSM state enum and the requester-ID width helper.
package dtc_pkg;

   localparam int IN_W_DEF  = 12;
   localparam int OUT_W_DEF = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      RESP = 2'd2
   } dtc_state_e;

   // Never narrower than one bit, so a single-requester build still elaborates.
   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dtc_rr_arb.sv
// Round-robin select: purely combinational, zero latency, no backpressure of its own.
// Picks the first valid requester at or after ptr, wrapping modulo N_REQ.
module dtc_rr_arb
   import dtc_pkg::*;
#(
   parameter  int N_REQ = 4,
   localparam int ID_W  = id_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req_valid,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  grant_idx,
   output logic             grant_any
);

   logic [ID_W-1:0] j;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      j         = '0;
      for (int k = 0; k < N_REQ; k++) begin
         j = ID_W'((int'(ptr) + k) % N_REQ);
         if (!grant_any && req_valid[j]) begin
            grant_any = 1'b1;
            grant[j]  = 1'b1;
            grant_idx = j;
         end
      end
   end

endmodule

// File: rtl/dtc_share_ctrl.sv
// Time-shares one external classifier among N_REQ requesters; accept->rsp_valid is 2 cycles.
// Holds the response until rsp_ready; no new request is granted outside IDLE.
module dtc_share_ctrl
   import dtc_pkg::*;
#(
   parameter  int N_REQ = 4,
   parameter  int IN_W  = IN_W_DEF,
   parameter  int OUT_W = OUT_W_DEF,
   parameter  int CNT_W = 16,
   localparam int ID_W  = id_w(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*IN_W-1:0]   req_data,
   output logic [N_REQ-1:0]        req_ready,
   output logic [IN_W-1:0]         cls_inp,
   input  logic [OUT_W-1:0]        cls_outp,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [OUT_W-1:0]        rsp_class,
   output logic [ID_W-1:0]         rsp_id,
   output logic [CNT_W-1:0]        done_cnt,
   output logic                    busy
);

   dtc_state_e       state_q, state_d;
   logic [ID_W-1:0]  ptr_q;
   logic [N_REQ-1:0] gnt;
   logic [ID_W-1:0]  gnt_idx;
   logic             gnt_any;
   logic             accept;
   logic             rsp_hs;

   dtc_rr_arb #(.N_REQ(N_REQ)) u_arb (
      .req_valid (req_valid),
      .ptr       (ptr_q),
      .grant     (gnt),
      .grant_idx (gnt_idx),
      .grant_any (gnt_any)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      req_ready = '0;
      rsp_valid = 1'b0;
      busy      = 1'b1;
      accept    = 1'b0;
      rsp_hs    = 1'b0;
      case (state_q)
         IDLE: begin
            busy      = 1'b0;
            req_ready = gnt;
            if (gnt_any) begin
               accept  = 1'b1;
               state_d = EVAL;
            end
         end
         EVAL: state_d = RESP;
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               rsp_hs  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // cls_inp only changes on acceptance, so the tree input is stable through EVAL and beyond.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cls_inp   <= '0;
         rsp_class <= '0;
         rsp_id    <= '0;
         ptr_q     <= '0;
         done_cnt  <= '0;
      end else begin
         if (accept) begin
            cls_inp <= req_data[int'(gnt_idx)*IN_W +: IN_W];
            rsp_id  <= gnt_idx;
            ptr_q   <= (gnt_idx == ID_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
         end
         if (state_q == EVAL) rsp_class <= cls_outp;
         if (rsp_hs && (done_cnt != '1)) done_cnt <= done_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_dtc_share_ctrl.sv
// Bench for dtc_share_ctrl: two instances (16-bit and 4-bit counters) driven in lockstep,
// checked against a transaction-level round-robin / classifier reference.
module tb_dtc_share_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [47:0] req_data;
   logic        rsp_ready;

   logic [3:0]  req_ready, req_ready4;
   logic [11:0] cls_inp, cls_inp4;
   logic [2:0]  cls_outp, cls_outp4;
   logic        rsp_valid, rsp_valid4;
   logic [2:0]  rsp_class, rsp_class4;
   logic [1:0]  rsp_id, rsp_id4;
   logic [15:0] done_cnt;
   logic [3:0]  done_cnt4;
   logic        busy, busy4;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int exp_cnt = 0;
   int ptr_m   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in for the shared tree: the two known leaf values, a fixed hash elsewhere.
   function automatic logic [2:0] cls_model(input logic [11:0] x);
      if (x == 12'h000) return 3'b111;
      if (x == 12'h001) return 3'b100;
      return x[2:0] ^ x[6:4] ^ x[11:9];
   endfunction

   assign cls_outp  = cls_model(cls_inp);
   assign cls_outp4 = cls_model(cls_inp4);

   dtc_share_ctrl dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .cls_inp(cls_inp), .cls_outp(cls_outp),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_class(rsp_class),
      .rsp_id(rsp_id), .done_cnt(done_cnt), .busy(busy)
   );

   dtc_share_ctrl #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready4), .cls_inp(cls_inp4), .cls_outp(cls_outp4),
      .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_class(rsp_class4),
      .rsp_id(rsp_id4), .done_cnt(done_cnt4), .busy(busy4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference arbiter: first valid index at or after the pointer, modulo 4.
   function automatic int rr_pick(input logic [3:0] m, input int p);
      for (int k = 0; k < 4; k++)
         if (m[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   function automatic int sat15(input int n);
      return (n > 15) ? 15 : n;
   endfunction

   // One full transaction starting in IDLE; bp = cycles rsp_ready is held low in RESP.
   task automatic txn(input logic [3:0] mask, input int bp);
      int          who;
      int          start;
      logic [11:0] d;
      logic [2:0]  c;
      who   = rr_pick(mask, ptr_m);
      d     = req_data[who*12 +: 12];
      c     = cls_model(d);
      start = cyc;
      req_valid = mask;
      rsp_ready = (bp == 0);
      #1;
      chk("grant", req_ready, 32'(1 << who));
      chk("idle_busy", busy, 0);
      @(posedge clk); #1;
      chk("eval_cls_inp", cls_inp, d);
      chk("eval_req_ready", req_ready, 0);
      chk("eval_rsp_valid", rsp_valid, 0);
      chk("eval_busy", busy, 1);
      @(posedge clk); #1;
      chk("resp_valid", rsp_valid, 1);
      chk("resp_class", rsp_class, c);
      chk("resp_id", rsp_id, who);
      chk("resp_req_ready", req_ready, 0);
      for (int i = 0; i < bp; i++) begin
         @(posedge clk); #1;
         chk("bp_valid", rsp_valid, 1);
         chk("bp_class", rsp_class, c);
         chk("bp_id", rsp_id, who);
         chk("bp_req_ready", req_ready, 0);
         chk("bp_done_cnt", done_cnt, exp_cnt);
         if (i == bp - 1) rsp_ready = 1'b1;
      end
      @(posedge clk); #1;
      exp_cnt++;
      ptr_m = (who + 1) % 4;
      chk("rsp_valid_drop", rsp_valid, 0);
      chk("done_cnt", done_cnt, exp_cnt);
      chk("done_cnt4", done_cnt4, sat15(exp_cnt));
      chk("spacing", cyc - start, 3 + bp);
      req_valid = '0;
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_class", rsp_class, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_cls_inp", cls_inp, 0);
      chk("rst_done_cnt", done_cnt, 0);
      rst_n = 1'b1;

      // Single request, then requester 2 with vector 001.
      req_data[0 +: 12] = 12'h000;
      txn(4'b0001, 0);
      chk("single_class", rsp_class, 3'b111);
      req_data[24 +: 12] = 12'h001;
      txn(4'b0100, 0);
      chk("second_class", rsp_class, 3'b100);
      chk("second_id", rsp_id, 2);

      // Bring the pointer back to 0, then all four held continuously.
      req_data = {16'($urandom), 32'($urandom)};
      txn(4'b1000, 0);
      for (int i = 0; i < 5; i++) begin
         req_valid = 4'hF;
         #1;
         chk("fair_grant", req_ready, 32'(1 << (i % 4)));
         txn(4'hF, 0);
      end

      // Ten stalled cycles in RESP.
      req_data = {16'($urandom), 32'($urandom)};
      txn(4'b0100, 10);

      // Reset while the request is in EVAL.
      req_valid = 4'b0010;
      #1;
      chk("pre_rst_grant", req_ready, 32'(1 << rr_pick(4'b0010, ptr_m)));
      @(posedge clk); #1;
      chk("pre_rst_busy", busy, 1);
      req_valid = '0;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_rsp_valid", rsp_valid, 0);
      chk("arst_cls_inp", cls_inp, 0);
      chk("arst_rsp_class", rsp_class, 0);
      chk("arst_rsp_id", rsp_id, 0);
      chk("arst_done_cnt", done_cnt, 0);
      chk("arst_done_cnt4", done_cnt4, 0);
      chk("arst_req_ready", req_ready, 0);
      @(posedge clk); #1;
      rst_n   = 1'b1;
      exp_cnt = 0;
      ptr_m   = 0;
      repeat (3) begin
         @(posedge clk); #1;
         chk("no_replay_valid", rsp_valid, 0);
         chk("no_replay_busy", busy, 0);
      end
      req_valid = 4'hF;
      #1;
      chk("post_rst_grant", req_ready, 32'h1);
      txn(4'hF, 0);

      // Random traffic; also drives the 4-bit counter into saturation.
      repeat (20) begin
         req_data = {16'($urandom), 32'($urandom)};
         txn(4'($urandom_range(1, 15)), int'($urandom_range(0, 2)));
      end
      chk("sat_done_cnt4", done_cnt4, 4'hF);
      chk("sat_done_cnt", done_cnt, 21);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dtc_share_ctrl.md
# dtc_share_ctrl

Time-shares one combinational decision-tree classifier (12-bit feature vector in, 3-bit class out, e.g. `dtc_split875_bm74`) among several requesters. Arbitration is round-robin. The block registers the selected feature vector in front of the classifier and captures the class one cycle later. The result is returned with the requester ID over a valid/ready response channel. The block sits between feature-producing front ends and the single shared tree instance, and it keeps a saturating count of completed classifications.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `IN_W`, default 12: feature vector width.
- `OUT_W`, default 3: class code width.
- `CNT_W`, default 16: width of the completion counter.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `req_valid` input N_REQ: per-requester request valid.
- `req_data` input N_REQ*IN_W: feature vectors; requester i occupies bits [i*IN_W +: IN_W].
- `req_ready` output N_REQ: one-hot grant; a request is accepted when `req_valid[i] & req_ready[i]`.
- `cls_inp` output IN_W: registered feature vector driven to the classifier.
- `cls_outp` input OUT_W: combinational class returned by the classifier.
- `rsp_valid` output 1: response valid.
- `rsp_ready` input 1: response consumer ready.
- `rsp_class` output OUT_W: captured class code.
- `rsp_id` output $clog2(N_REQ): index of the requester that owns the response.
- `done_cnt` output CNT_W: number of completed responses, saturating.
- `busy` output 1: high in every state except IDLE.

## Operation
- The FSM has three states: IDLE, EVAL and RESP. Reset state is IDLE.
- **IDLE:** the arbiter selects a requester and `req_ready` is driven one-hot to it, combinationally from `req_valid` and the pointer.
  - If any `req_valid` bit is high, the grant is accepted that cycle.
  - On acceptance, `cls_inp` <= selected `req_data` slice, the ID is latched, and the FSM moves to EVAL.
  - With no valid request, `req_ready` is all zeros and the FSM stays in IDLE.
- **EVAL:** `cls_inp` is stable. At the end of the cycle, `rsp_class` <= `cls_outp` and the FSM moves to RESP. `req_ready` is all zeros.
- **RESP:** `rsp_valid` is high.
  - On `rsp_valid & rsp_ready`: `done_cnt` increments (saturating at all-ones) and the FSM moves to IDLE.
  - Otherwise the FSM stays in RESP and `rsp_class` and `rsp_id` hold.
  - `req_ready` is all zeros.
- **Round robin:**
  - The pointer resets to 0.
  - The grant goes to the lowest index j at or after the pointer (wrapping modulo N_REQ) with `req_valid[j]` high.
  - After an accepted grant to index i, pointer <= (i+1) mod N_REQ.
  - The pointer does not move when nothing is granted.
- `cls_inp` holds its last value outside EVAL. It is never cleared except by reset.
- **Reset mid-operation:** all state is forced to reset values immediately.
  - Any in-flight request and any pending response are discarded, not replayed.
  - `done_cnt` is not incremented.
- A requester that drops `req_valid` before it is granted loses nothing; no request is stored before acceptance.

## Timing
- Reset values:
  - `req_ready` = 0, `rsp_valid` = 0, `busy` = 0.
  - `rsp_class` = 0, `rsp_id` = 0, `cls_inp` = 0.
  - `done_cnt` = 0, pointer = 0, state = IDLE.
- Acceptance at cycle t:
  - `cls_inp` is valid at t+1.
  - `rsp_valid` rises at t+2, assuming `cls_outp` settles within one cycle.
- Minimum spacing between acceptances is 3 cycles (IDLE, EVAL, RESP with `rsp_ready` high).
- `rsp_valid` never drops without a handshake except on reset.
- `done_cnt` updates on the cycle after the handshake edge.

## Structure
- Shared package `dtc_pkg` holds:
  - the `IN_W`/`OUT_W` defaults;
  - the state enum `dtc_state_e` {IDLE, EVAL, RESP};
  - an ID width helper.
- Sub-module `dtc_rr_arb` is a purely combinational round-robin select from `req_valid` and the pointer. It outputs the one-hot grant and the encoded index.
- The pointer register and FSM live in `dtc_share_ctrl`.
- The classifier is external, not instantiated inside this block.

## Test plan
- **Single request:** bench binds `dtc_split875_bm74`. `req_valid` = 0001, `req_data[0]` = 12'h000. Required: grant at t, `cls_inp` = 12'h000 at t+1, `rsp_valid` at t+2 with class 3'b111, id 0, `done_cnt` = 1.
- **Second vector:** requester 2 sends 12'h001. Required: `rsp_class` = 3'b100, `rsp_id` = 2.
- **Fairness:** `req_valid` = 1111 held continuously with `rsp_ready` = 1. Required: grant order 0,1,2,3,0, every 3 cycles; `done_cnt` = 5 after five handshakes.
- **Backpressure:** `rsp_ready` = 0 for 10 cycles in RESP. Required:
  - `rsp_valid`, `rsp_class` and `rsp_id` stable throughout;
  - `req_ready` = 0 throughout;
  - completion happens only on the `rsp_ready` cycle.
- **Reset during EVAL:** pulse `rst_n` low. Required:
  - all outputs return to reset values asynchronously;
  - no response is produced;
  - the next grant goes to requester 0.
- **Saturation:** `CNT_W` = 4, run 20 transactions. Required: `done_cnt` stops at 4'hF.
